hyperram_target_stm: RTL and testbench

Synthesizable HyperRAM device-side responder: the target end of the bus that the controller's read/write state machines drive. It decodes the 48-bit command/address (CA) from three 16-bit words and signals the CA window and data strobes on RWDS. It serves memory and register reads, and accepts memory and register writes into a small internal array. It sits behind the same 16-bit-per-clock word abstraction as the controller and is used for on-chip loopback and simulation of the controller without a physical device.

---
 rtl/hyperram_pkg.sv | 48 ++++
 rtl/hyperram_target_mem.sv | 35 +++
 rtl/hyperram_target_stm.sv | 264 ++++++++++++++++++++++++++
 tb/tb_hyperram_target_stm.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hyperram_pkg.sv
// hyperram_pkg
// Shared definitions for the HyperRAM word-level bus: command/address (CA)
// bit positions, register map, register reset defaults, wrapped-burst group
// size and the target state encoding used by the device-side responder and
// the controller state machines that talk to it.
package hyperram_pkg;

  // Command/address word layout (48 bits, sent as three 16-bit words)
  localparam int CA_W           = 48;
  localparam int CA_RW_BIT      = 47;  // 1 = read
  localparam int CA_AS_BIT      = 46;  // 1 = register space
  localparam int CA_BURST_BIT   = 45;  // 1 = linear, 0 = wrapped
  localparam int CA_ADDR_HI     = 44;  // upper word-address field CA[44:16]
  localparam int CA_ADDR_MID_LO = 16;
  localparam int CA_ADDR_LO_HI  = 2;   // lower word-address field CA[2:0]

  // Register map; only word-address bits [11] and [0] take part in decode
  localparam int          REG_SEL_HI_BIT = 11;
  localparam logic [31:0] REG_ID0_ADDR   = 32'h0000_0000;
  localparam logic [31:0] REG_ID1_ADDR   = 32'h0000_0001;
  localparam logic [31:0] REG_CR0_ADDR   = 32'h0000_0800;
  localparam logic [31:0] REG_CR1_ADDR   = 32'h0000_0801;

  localparam logic [1:0] REG_SEL_ID0 = {REG_ID0_ADDR[REG_SEL_HI_BIT], REG_ID0_ADDR[0]};
  localparam logic [1:0] REG_SEL_ID1 = {REG_ID1_ADDR[REG_SEL_HI_BIT], REG_ID1_ADDR[0]};
  localparam logic [1:0] REG_SEL_CR0 = {REG_CR0_ADDR[REG_SEL_HI_BIT], REG_CR0_ADDR[0]};
  localparam logic [1:0] REG_SEL_CR1 = {REG_CR1_ADDR[REG_SEL_HI_BIT], REG_CR1_ADDR[0]};

  // Register contents / reset defaults
  localparam logic [15:0] ID0_DEFAULT = 16'h0C81;
  localparam logic [15:0] ID1_DEFAULT = 16'h0000;
  localparam logic [15:0] CR0_DEFAULT = 16'h8F1F;
  localparam logic [15:0] CR1_DEFAULT = 16'hFFC1;

  // Wrapped bursts stay inside an aligned group of this many words
  localparam int WRAP_GROUP = 16;

  // Target state encoding
  typedef logic [2:0] target_state_t;
  localparam target_state_t TST_IDLE  = 3'd0;
  localparam target_state_t TST_CA    = 3'd1;
  localparam target_state_t TST_LAT   = 3'd2;
  localparam target_state_t TST_RDATA = 3'd3;
  localparam target_state_t TST_WDATA = 3'd4;
  localparam target_state_t TST_REGW  = 3'd5;
  localparam target_state_t TST_HOLD  = 3'd6;

endpackage

// File: rtl/hyperram_target_mem.sv
// hyperram_target_mem
// Word-wide storage array behind the HyperRAM target. One synchronous write
// port and one combinational read port; contents are not reset.
// Ports:
//   clk    clock
//   we     write enable (already qualified with the write mask)
//   waddr  write word index
//   wdata  write word
//   raddr  read word index
//   rdata  read word, combinational from raddr
module hyperram_target_mem #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hyperram_target_stm.sv
// hyperram_target_stm
// Device-side HyperRAM responder working on the 16-bit-per-clock word
// abstraction. Collects the 48-bit CA over three words, flags the CA window
// on RWDS, then serves memory/register reads and accepts memory/register
// writes after the configured latency (register writes have none).
// Ports:
//   clk       clock
//   rst       synchronous active-high reset
//   csn       chip select, active low; high aborts the access at the next edge
//   dq_in     controller word (CA, write data)
//   dq_out    read data word
//   dq_oe     target drives dq_out
//   rwds_in   write mask, 1 = discard this data word
//   rwds_out  CA-window flag / read data strobe
//   rwds_oe   target drives rwds_out
module hyperram_target_stm
  import hyperram_pkg::*;
#(
  parameter int          ADDR_W  = 6,
  parameter int          LATENCY = 12,
  parameter logic [15:0] ID0_VAL = ID0_DEFAULT,
  parameter logic [15:0] ID1_VAL = ID1_DEFAULT,
  parameter logic [15:0] CR0_RST = CR0_DEFAULT,
  parameter logic [15:0] CR1_RST = CR1_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csn,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  input  logic        rwds_in,
  output logic        rwds_out,
  output logic        rwds_oe
);

  localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [ADDR_W-1:0] WRAP_MASK = ADDR_W'(WRAP_GROUP - 1);

  target_state_t     state_reg,    state_next;
  logic [31:0]       ca_reg,       ca_next;
  logic [1:0]        ca_cnt_reg,   ca_cnt_next;
  logic [CNT_W-1:0]  lat_cnt_reg,  lat_cnt_next;
  logic [ADDR_W-1:0] addr_reg,     addr_next;
  logic [1:0]        sel_reg,      sel_next;
  logic              rd_reg,       rd_next;
  logic              regsp_reg,    regsp_next;
  logic              lin_reg,      lin_next;
  logic [15:0]       cr0_reg,      cr0_next;
  logic [15:0]       cr1_reg,      cr1_next;
  logic [15:0]       dq_out_reg,   dq_out_next;
  logic              dq_oe_reg,    dq_oe_next;
  logic              rwds_out_reg, rwds_out_next;
  logic              rwds_oe_reg,  rwds_oe_next;

  // Full CA as seen on the third CA edge: two shifted words plus the live bus
  logic [CA_W-1:0]   ca_full;
  logic [31:0]       ca_wa;
  logic [ADDR_W-1:0] ca_idx;
  logic [1:0]        ca_sel;
  logic              ca_last;
  logic              ca_regwr;
  logic              ca_unused;

  // Attributes of the word being transferred on this edge. On the final CA
  // edge they come straight from the bus, otherwise from the latched CA.
  logic [ADDR_W-1:0] act_idx;
  logic [1:0]        act_sel;
  logic              act_rd;
  logic              act_regsp;
  logic              act_lin;
  logic              data_act;

  logic [ADDR_W-1:0] idx_inc;
  logic [ADDR_W-1:0] idx_wrap;
  logic [ADDR_W-1:0] idx_next;
  logic [15:0]       reg_rdata;
  logic [15:0]       mem_rdata;
  logic [15:0]       rd_word;
  logic              mem_we;

  assign ca_full  = {ca_reg, dq_in};
  assign ca_wa    = {ca_full[CA_ADDR_HI:CA_ADDR_MID_LO], ca_full[CA_ADDR_LO_HI:0]};
  assign ca_idx   = ca_wa[ADDR_W-1:0];
  assign ca_sel   = {ca_wa[REG_SEL_HI_BIT], ca_wa[0]};
  assign ca_last  = (state_reg == TST_CA) && (ca_cnt_reg == 2'd2);
  assign ca_regwr = ca_full[CA_AS_BIT] && !ca_full[CA_RW_BIT];

  // Upper address and reserved CA bits are not decoded by this small target
  assign ca_unused = ^{ca_full, ca_wa};

  assign act_idx   = ca_last ? ca_idx                  : addr_reg;
  assign act_sel   = ca_last ? ca_sel                  : sel_reg;
  assign act_rd    = ca_last ? ca_full[CA_RW_BIT]      : rd_reg;
  assign act_regsp = ca_last ? ca_full[CA_AS_BIT]      : regsp_reg;
  assign act_lin   = ca_last ? ca_full[CA_BURST_BIT]   : lin_reg;

  // A data word moves on this edge: every edge of a data phase, the edge on
  // which the latency count expires, or the final CA edge at zero latency.
  assign data_act = !csn &&
                    ((state_reg == TST_RDATA) || (state_reg == TST_WDATA) ||
                     ((state_reg == TST_LAT) && (lat_cnt_reg == CNT_W'(1))) ||
                     (ca_last && (LATENCY == 0) && !ca_regwr));

  // Linear bursts roll over the whole array; wrapped bursts stay inside
  // their aligned group.
  assign idx_inc  = act_idx + ADDR_W'(1);
  assign idx_wrap = (act_idx & ~WRAP_MASK) | (idx_inc & WRAP_MASK);
  assign idx_next = act_lin ? idx_inc : idx_wrap;

  always_comb begin
    reg_rdata = ID0_VAL;
    case (act_sel)
      REG_SEL_ID0: reg_rdata = ID0_VAL;
      REG_SEL_ID1: reg_rdata = ID1_VAL;
      REG_SEL_CR0: reg_rdata = cr0_reg;
      REG_SEL_CR1: reg_rdata = cr1_reg;
      default:     reg_rdata = ID0_VAL;
    endcase
  end

  assign rd_word = act_regsp ? reg_rdata : mem_rdata;
  assign mem_we  = data_act && !act_rd && !act_regsp && !rwds_in;

  hyperram_target_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (16)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (act_idx),
    .wdata (dq_in),
    .raddr (act_idx),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_next    = state_reg;
    ca_next       = ca_reg;
    ca_cnt_next   = ca_cnt_reg;
    lat_cnt_next  = lat_cnt_reg;
    addr_next     = addr_reg;
    sel_next      = sel_reg;
    rd_next       = rd_reg;
    regsp_next    = regsp_reg;
    lin_next      = lin_reg;
    cr0_next      = cr0_reg;
    cr1_next      = cr1_reg;
    dq_out_next   = dq_out_reg;
    dq_oe_next    = dq_oe_reg;
    rwds_out_next = rwds_out_reg;
    rwds_oe_next  = rwds_oe_reg;

    if (csn) begin
      // Deselect ends any access; writes already committed stay.
      state_next    = TST_IDLE;
      dq_out_next   = 16'h0000;
      dq_oe_next    = 1'b0;
      rwds_out_next = 1'b0;
      rwds_oe_next  = 1'b0;
    end else begin
      case (state_reg)
        TST_IDLE: begin
          state_next    = TST_CA;
          ca_cnt_next   = 2'd0;
          rwds_oe_next  = 1'b1;
          rwds_out_next = 1'b1;
        end
        TST_CA: begin
          ca_next     = {ca_reg[15:0], dq_in};
          ca_cnt_next = ca_cnt_reg + 2'd1;
          if (ca_last) begin
            rwds_oe_next  = 1'b0;
            rwds_out_next = 1'b0;
            addr_next     = ca_idx;
            sel_next      = ca_sel;
            rd_next       = ca_full[CA_RW_BIT];
            regsp_next    = ca_full[CA_AS_BIT];
            lin_next      = ca_full[CA_BURST_BIT];
            lat_cnt_next  = CNT_W'(LATENCY);
            if (ca_regwr) begin
              state_next = TST_REGW;
            end else if (LATENCY != 0) begin
              state_next = TST_LAT;
            end
          end
        end
        TST_LAT: begin
          if (lat_cnt_reg != CNT_W'(1)) begin
            lat_cnt_next = lat_cnt_reg - CNT_W'(1);
          end
        end
        TST_REGW: begin
          // ID registers are read-only, so only the CR selects take data
          if (sel_reg == REG_SEL_CR0) begin
            cr0_next = dq_in;
          end else if (sel_reg == REG_SEL_CR1) begin
            cr1_next = dq_in;
          end
          state_next = TST_HOLD;
        end
        TST_RDATA, TST_WDATA, TST_HOLD: begin
        end
        default: begin
          state_next = TST_IDLE;
        end
      endcase

      if (data_act) begin
        state_next = act_rd ? TST_RDATA : TST_WDATA;
        // Register reads keep returning the same register
        addr_next  = idx_next;
        if (act_rd) begin
          dq_out_next   = rd_word;
          dq_oe_next    = 1'b1;
          rwds_oe_next  = 1'b1;
          rwds_out_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= TST_IDLE;
      ca_reg       <= 32'h0;
      ca_cnt_reg   <= 2'd0;
      lat_cnt_reg  <= '0;
      addr_reg     <= '0;
      sel_reg      <= 2'd0;
      rd_reg       <= 1'b0;
      regsp_reg    <= 1'b0;
      lin_reg      <= 1'b0;
      cr0_reg      <= CR0_RST;
      cr1_reg      <= CR1_RST;
      dq_out_reg   <= 16'h0000;
      dq_oe_reg    <= 1'b0;
      rwds_out_reg <= 1'b0;
      rwds_oe_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ca_reg       <= ca_next;
      ca_cnt_reg   <= ca_cnt_next;
      lat_cnt_reg  <= lat_cnt_next;
      addr_reg     <= addr_next;
      sel_reg      <= sel_next;
      rd_reg       <= rd_next;
      regsp_reg    <= regsp_next;
      lin_reg      <= lin_next;
      cr0_reg      <= cr0_next;
      cr1_reg      <= cr1_next;
      dq_out_reg   <= dq_out_next;
      dq_oe_reg    <= dq_oe_next;
      rwds_out_reg <= rwds_out_next;
      rwds_oe_reg  <= rwds_oe_next;
    end
  end

  assign dq_out   = dq_out_reg;
  assign dq_oe    = dq_oe_reg;
  assign rwds_out = rwds_out_reg;
  assign rwds_oe  = rwds_oe_reg;

endmodule

// File: tb/tb_hyperram_target_stm.sv
// tb_hyperram_target_stm
// Drives directed and random HyperRAM transactions into the target and
// compares every observed output word against a memory/register model.
module tb_hyperram_target_stm;

  localparam int          ADDR_W  = 6;
  localparam int          DEPTH   = 64;
  localparam int          LAT     = 12;
  localparam logic [15:0] ID0_V   = 16'h0C81;
  localparam logic [15:0] ID1_V   = 16'h0000;
  localparam logic [15:0] CR0_R   = 16'h8F1F;
  localparam logic [15:0] CR1_R   = 16'hFFC1;

  logic        clk = 1'b0;
  logic        rst;
  logic        csn;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        rwds_in;
  logic        rwds_out;
  logic        rwds_oe;

  int n_checks = 0;
  int n_errors = 0;
  int txn_no   = 0;

  logic [15:0] mem_m [0:DEPTH-1];
  logic [15:0] cr0_m;
  logic [15:0] cr1_m;
  logic [15:0] wbuf  [0:127];
  logic        mbuf  [0:127];

  logic [47:0] rca;
  logic [63:0] r64;
  int          rnw;
  int          kind;

  hyperram_target_stm #(
    .ADDR_W  (ADDR_W),
    .LATENCY (LAT),
    .ID0_VAL (ID0_V),
    .ID1_VAL (ID1_V),
    .CR0_RST (CR0_R),
    .CR1_RST (CR1_R)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .csn      (csn),
    .dq_in    (dq_in),
    .dq_out   (dq_out),
    .dq_oe    (dq_oe),
    .rwds_in  (rwds_in),
    .rwds_out (rwds_out),
    .rwds_oe  (rwds_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (txn %0d, t=%0t)", tag, got, exp, txn_no, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input logic rs, input logic [1:0] sel, input int idx);
    if (!rs) return mem_m[idx];
    case (sel)
      2'd0:    return ID0_V;
      2'd1:    return ID1_V;
      2'd2:    return cr0_m;
      default: return cr1_m;
    endcase
  endfunction

  function automatic int next_idx(input int idx, input logic lin, input logic rs);
    if (rs)  return idx;
    if (lin) return (idx + 1) % DEPTH;
    return (idx / 16) * 16 + ((idx + 1) % 16);
  endfunction

  // One transaction: three CA words, LAT cycles of latency, then nw data
  // words. rst_at > 0 asserts reset at that cycle index instead of finishing.
  task automatic run_txn(input logic [47:0] ca, input int nw, input int rst_at);
    logic [31:0] wa;
    logic        rd, rs, lin, exp_oe, rst_done;
    logic [1:0]  sel;
    int          idx, n_end, k;
    wa    = {ca[44:16], ca[2:0]};
    idx   = int'(wa[ADDR_W-1:0]);
    rd    = ca[47];
    rs    = ca[46];
    lin   = ca[45];
    sel   = {wa[11], wa[0]};
    n_end = (rs && !rd) ? 4 : 2 + LAT + nw;
    rst_done = 1'b0;
    txn_no++;
    $display("txn %0d: %s %s %s ca=%012h words=%0d%s", txn_no, rd ? "read " : "write",
             rs ? "reg" : "mem", lin ? "linear " : "wrapped", ca, (rs && !rd) ? 1 : nw,
             (rst_at > 0) ? " reset-mid-burst" : "");
    @(negedge clk);
    csn = 1'b0; dq_in = 16'h0; rwds_in = 1'b0;
    for (int n = 0; n <= n_end; n++) begin
      @(negedge clk);
      if (n < 3) begin
        chk("ca_rwds", 32'({rwds_oe, rwds_out}), 32'h3);
        dq_in = ca[47 - 16 * n -: 16];
      end else begin
        exp_oe = rd && (n >= 3 + LAT);
        chk("dq_oe", 32'(dq_oe), 32'(exp_oe));
        chk("rwds_oe", 32'(rwds_oe), 32'(exp_oe));
        if (exp_oe) begin
          chk("rdata", 32'(dq_out), 32'(model_read(rs, sel, idx)));
          chk("rwds_out", 32'(rwds_out), 32'h1);
          idx = next_idx(idx, lin, rs);
        end
        if (rst_at == n) begin
          rst = 1'b1; csn = 1'b1; rst_done = 1'b1;
          break;
        end
        if (n == n_end) begin
          csn = 1'b1; dq_in = 16'h0; rwds_in = 1'b0;
        end else if (!rd && rs) begin
          dq_in = wbuf[0]; rwds_in = 1'b0;
          if (sel == 2'd2) cr0_m = wbuf[0];
          else if (sel == 2'd3) cr1_m = wbuf[0];
        end else if (!rd && n >= 2 + LAT) begin
          k = n - 2 - LAT;
          dq_in = wbuf[k]; rwds_in = mbuf[k];
          if (!mbuf[k]) mem_m[idx] = wbuf[k];
          idx = next_idx(idx, lin, 1'b0);
        end else begin
          dq_in = 16'($urandom); rwds_in = 1'b0;
        end
      end
    end
    @(negedge clk);
    if (rst_done) begin
      chk("rst_outputs", {14'h0, dq_out, dq_oe, rwds_out, rwds_oe}, 32'h0);
      rst = 1'b0;
      cr0_m = CR0_R; cr1_m = CR1_R;
    end else begin
      chk("end_oe", 32'({dq_oe, rwds_oe}), 32'h0);
    end
    rwds_in = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; csn = 1'b1; dq_in = 16'h0; rwds_in = 1'b0;
    cr0_m = CR0_R; cr1_m = CR1_R;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {14'h0, dq_out, dq_oe, rwds_out, rwds_oe}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", 32'({dq_oe, rwds_oe, rwds_out}), 32'h0);

    // Fill the whole array so every later read has defined contents
    for (int i = 0; i < DEPTH; i++) begin
      wbuf[i] = 16'($urandom); mbuf[i] = 1'b0;
    end
    run_txn(48'h2000_0000_0000, DEPTH, 0);

    // ID0 read, and CR reset values
    run_txn(48'hC000_0000_0000, 4, 0);
    run_txn(48'hC000_0100_0000, 2, 0);
    run_txn(48'hC000_0100_0001, 2, 0);

    // Memory write then read back
    wbuf[0] = 16'hA5A5; wbuf[1] = 16'h5A5A; mbuf[0] = 1'b0; mbuf[1] = 1'b0;
    run_txn(48'h2000_0000_0002, 2, 0);
    run_txn(48'hA000_0000_0002, 2, 0);
    chk("wr_rd_model_idx2", 32'(mem_m[2]), 32'h0000_A5A5);

    // Masked second word leaves index 3 untouched
    wbuf[0] = 16'h1111; mbuf[0] = 1'b0;
    run_txn(48'h2000_0000_0003, 1, 0);
    wbuf[0] = 16'h2222; wbuf[1] = 16'h3333; mbuf[0] = 1'b0; mbuf[1] = 1'b1;
    run_txn(48'h2000_0000_0002, 2, 0);
    run_txn(48'hA000_0000_0002, 2, 0);

    // Register write to CR0, then read back
    wbuf[0] = 16'h8F17;
    run_txn(48'h6000_0100_0000, 1, 0);
    run_txn(48'hE000_0100_0000, 3, 0);
    // ID0 is read-only
    wbuf[0] = 16'hDEAD;
    run_txn(48'h6000_0000_0000, 1, 0);
    run_txn(48'hC000_0000_0000, 1, 0);

    // Wrapped and linear bursts across index 15
    run_txn(48'h8000_0001_0006, 4, 0);
    run_txn(48'hA000_0001_0006, 4, 0);
    // Linear burst across the top of the array
    run_txn(48'hA000_0007_0006, 4, 0);

    // Abort in the latency phase: no write happens
    wbuf[0] = 16'hBEEF; mbuf[0] = 1'b0;
    run_txn(48'h2000_0000_0005, 0, 0);
    run_txn(48'hA000_0000_0005, 1, 0);

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 7));
      r64  = {$urandom, $urandom};
      rca  = {1'b0, 1'b0, 1'b0, r64[44:0]};
      rca[47] = kind[0];
      rca[46] = (kind >= 6);
      rca[45] = kind[1];
      rnw = rca[47] ? int'($urandom_range(1, 20)) : int'($urandom_range(0, 20));
      for (int i = 0; i < rnw + 1; i++) begin
        wbuf[i] = 16'($urandom);
        mbuf[i] = ($urandom_range(0, 3) == 0);
      end
      run_txn(rca, rnw, 0);
    end

    // Reset in the middle of a read burst restores the CR defaults
    wbuf[0] = 16'h1234;
    run_txn(48'h6000_0100_0000, 1, 0);
    run_txn(48'hA000_0000_0000, 5, 3 + LAT + 2);
    run_txn(48'hE000_0100_0000, 2, 0);
    run_txn(48'hE000_0100_0001, 1, 0);
    run_txn(48'hA000_0000_0000, 3, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
